stream_demux2: RTL



---
 rtl/stream_pkg.sv | 13 +
 rtl/xfer_counter.sv | 29 ++
 rtl/stream_demux2.sv | 79 +++++++
 3 files changed

// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared types and defaults for the stream demultiplexer
package stream_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL0 = 2'd1,
        FULL1 = 2'd2
    } demux_state_t;

    localparam int DATA_W_DEF = 4;
    localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/xfer_counter.sv
// rtl/xfer_counter.sv - wrapping transfer counter with synchronous clear
module xfer_counter
    import stream_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    // clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/stream_demux2.sv
// rtl/stream_demux2.sv - 1:2 stream demux with one registered holding stage
// Optional per-port take counters: define STREAM_DEMUX2_CNT_EN.
module stream_demux2
    import stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
`ifdef STREAM_DEMUX2_CNT_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic              out1_valid,
    input  logic              out1_ready
`ifdef STREAM_DEMUX2_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
`endif
);

    demux_state_t      r_state;
    logic [DATA_W-1:0] r_data;
    logic              w_take0;
    logic              w_take1;
    logic              w_take;
    logic              w_acc;

    // ready on the port not addressed by the held word is ignored
    assign w_take0  = (r_state == FULL0) & out0_ready;
    assign w_take1  = (r_state == FULL1) & out1_ready;
    assign w_take   = w_take0 | w_take1;
    assign in_ready = (r_state == EMPTY) | w_take;
    assign w_acc    = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else if (w_acc) begin
            r_state <= in_sel ? FULL1 : FULL0;
            r_data  <= in_data;
        end else if (w_take) begin
            r_state <= EMPTY;
        end
    end

    assign out_data   = r_data;
    assign out0_valid = (r_state == FULL0);
    assign out1_valid = (r_state == FULL1);

`ifdef STREAM_DEMUX2_CNT_EN
    xfer_counter #(.CNT_W(CNT_W)) u_cnt0 (
        .clk (clk),
        .rst (rst),
        .inc (w_take0),
        .clr (cnt_clr),
        .cnt (cnt0)
    );

    xfer_counter #(.CNT_W(CNT_W)) u_cnt1 (
        .clk (clk),
        .rst (rst),
        .inc (w_take1),
        .clr (cnt_clr),
        .cnt (cnt1)
    );
`endif

endmodule
